input_current_scheduler: RTL



---
 rtl/input_current_scheduler_pkg.sv | 26 ++
 rtl/input_current_scheduler_if.sv | 31 +++
 rtl/input_current_scheduler_sat_accumulator.sv | 42 ++++
 rtl/input_current_scheduler.sv | 135 +++++++++++++
 4 files changed

// File: rtl/input_current_scheduler_pkg.sv
// Shared types, limits and width helpers for the input current scheduler.
package input_current_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [7:0] SAT_LIMIT = 8'hFF;

  // Ceiling log2, never below 1 so a degenerate count still yields a usable width.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/input_current_scheduler_if.sv
// Spike/weight/current bus between the scheduler and its surroundings.
interface input_current_scheduler_if
  import input_current_scheduler_pkg::*;
#(
  parameter int M = 24,
  parameter int N = 8
) ();
  localparam int ADDR_W = clog2_min1(N * M);
  localparam int NID_W  = clog2_min1(N);

  logic              start;
  logic [M-1:0]      input_spikes;
  logic              weight_rd;
  logic [ADDR_W-1:0] weight_addr;
  logic [7:0]        weight_data;
  logic              current_valid;
  logic [NID_W-1:0]  current_neuron;
  logic [7:0]        current_out;
  logic              busy;
  logic              done;

  modport slave (
    input  start, input_spikes, weight_data,
    output weight_rd, weight_addr, current_valid, current_neuron, current_out, busy, done
  );

  modport master (
    output start, input_spikes, weight_data,
    input  weight_rd, weight_addr, current_valid, current_neuron, current_out, busy, done
  );
endinterface

// File: rtl/input_current_scheduler_sat_accumulator.sv
// Clear/add-enable accumulator exposing an 8-bit saturated view of the value being written.
module sat_accumulator
  import input_current_scheduler_pkg::*;
#(
  parameter int ACC_W = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_add_en,
  input  logic [7:0] i_add_val,
  output logic [7:0] o_sat_next
);
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_next;

  // Next accumulator value: clear wins over add.
  always_comb begin
    w_acc_next = r_acc;
    if (i_clear) begin
      w_acc_next = '0;
    end else if (i_add_en) begin
      w_acc_next = r_acc + ACC_W'(i_add_val);
    end else begin
      w_acc_next = r_acc;
    end
  end

  // Saturated view lets the caller register the final sum on the same edge it is formed.
  always_comb begin
    o_sat_next = (w_acc_next > ACC_W'(SAT_LIMIT)) ? SAT_LIMIT : w_acc_next[7:0];
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_next;
    end
  end
endmodule

// File: rtl/input_current_scheduler.sv
// Time-multiplexes one accumulator over N neurons x M synapses, emitting one saturated current per neuron.
module input_current_scheduler
  import input_current_scheduler_pkg::*;
#(
  parameter int M = 24,
  parameter int N = 8
) (
  input logic                      clk,
  input logic                      reset,
  input_current_scheduler_if.slave bus
);
  localparam int ADDR_W = clog2_min1(N * M);
  localparam int NID_W  = clog2_min1(N);
  localparam int S_W    = clog2_min1(M);
  localparam int ACC_W  = 8 + clog2_min1(M + 1);
  localparam logic [S_W-1:0]   S_LAST = S_W'(M - 1);
  localparam logic [NID_W-1:0] N_LAST = NID_W'(N - 1);

  state_e            r_state, w_state_nxt;
  logic [S_W-1:0]    r_syn, w_syn_nxt;
  logic [NID_W-1:0]  r_nid, w_nid_nxt;
  logic [M-1:0]      r_spikes, w_spikes_nxt;
  logic              r_rd_d;
  logic [S_W-1:0]    r_syn_d;
  logic              r_weight_rd;
  logic [ADDR_W-1:0] r_weight_addr, w_addr_nxt;
  logic              r_current_valid;
  logic [NID_W-1:0]  r_current_neuron;
  logic [7:0]        r_current_out;
  logic              r_busy, r_done;
  logic              w_acc_clear, w_acc_add;
  logic [7:0]        w_sat_next;

  // Data returning this cycle belongs to the synapse read last cycle.
  assign w_acc_add   = r_rd_d & r_spikes[r_syn_d];
  assign w_acc_clear = (r_state == ST_EMIT) || ((r_state == ST_IDLE) && bus.start);

  sat_accumulator #(.ACC_W(ACC_W)) u_acc (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_acc_clear),
    .i_add_en   (w_acc_add),
    .i_add_val  (bus.weight_data),
    .o_sat_next (w_sat_next)
  );

  // Next-state and index logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_syn_nxt    = r_syn;
    w_nid_nxt    = r_nid;
    w_spikes_nxt = r_spikes;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt  = ST_FETCH;
          w_syn_nxt    = '0;
          w_nid_nxt    = '0;
          w_spikes_nxt = bus.input_spikes;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (r_syn == S_LAST) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_syn_nxt = r_syn + S_W'(1);
        end
      end
      ST_DRAIN: w_state_nxt = ST_EMIT;
      ST_EMIT: begin
        w_syn_nxt = '0;
        if (r_nid == N_LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_nid_nxt   = r_nid + NID_W'(1);
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_addr_nxt = (w_state_nxt == ST_FETCH)
                    ? (ADDR_W'(w_nid_nxt) * ADDR_W'(M) + ADDR_W'(w_syn_nxt))
                    : '0;

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_syn            <= '0;
      r_nid            <= '0;
      r_spikes         <= '0;
      r_rd_d           <= 1'b0;
      r_syn_d          <= '0;
      r_weight_rd      <= 1'b0;
      r_weight_addr    <= '0;
      r_current_valid  <= 1'b0;
      r_current_neuron <= '0;
      r_current_out    <= 8'h00;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_syn           <= w_syn_nxt;
      r_nid           <= w_nid_nxt;
      r_spikes        <= w_spikes_nxt;
      r_rd_d          <= r_weight_rd;
      r_syn_d         <= r_syn;
      r_weight_rd     <= (w_state_nxt == ST_FETCH);
      r_weight_addr   <= w_addr_nxt;
      r_current_valid <= (w_state_nxt == ST_EMIT);
      if (w_state_nxt == ST_EMIT) begin
        r_current_out    <= w_sat_next;
        r_current_neuron <= w_nid_nxt;
      end else begin
        r_current_out    <= r_current_out;
        r_current_neuron <= r_current_neuron;
      end
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.weight_rd      = r_weight_rd;
  assign bus.weight_addr    = r_weight_addr;
  assign bus.current_valid  = r_current_valid;
  assign bus.current_neuron = r_current_neuron;
  assign bus.current_out    = r_current_out;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
endmodule
